// File: rtl/ahb_sram_subordinate.sv
// ahb_sram_subordinate
// Single-manager AHB subordinate backed by a word-organised on-chip SRAM.
// It inserts WAIT_STATES HREADY-low cycles into every OKAY data phase and
// supports byte-lane writes through HSIZE/HADDR lane selection and HWSTRB.
// The block's own HREADY is the bus HREADY, so it is for point-to-point use.
//
// Optional feature macro: AHB_SUB_ERR_EN
//   defined   - out-of-range, oversize or misaligned transfers get a
//               two-cycle ERROR response (ERR1, ERR2) with no memory access.
//   undefined - no ERROR states; the address wraps modulo the memory size,
//               an oversize HSIZE becomes a full-width access and misaligned
//               low address bits are cleared. HRESP is tied to 0.
module ahb_sram_subordinate #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,   // 32 or 64
    parameter int MEM_DEPTH   = 1024, // words, power of two
    parameter int WAIT_STATES = 0     // 0..15
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic [ADDR_WIDTH-1:0]   HADDR,
    input  logic                    HWRITE,
    input  logic [2:0]              HSIZE,
    input  logic [1:0]              HTRANS,
    input  logic [2:0]              HBURST,
    input  logic [3:0]              HPROT,
    input  logic                    HMASTLOCK,
    input  logic [DATA_WIDTH-1:0]   HWDATA,
    input  logic [DATA_WIDTH/8-1:0] HWSTRB,
    output logic                    HREADY,
    output logic                    HRESP,
    output logic [DATA_WIDTH-1:0]   HRDATA
);

    localparam int         BYTE_LANES = DATA_WIDTH / 8;
    localparam int         LANE_BITS  = $clog2(BYTE_LANES);
    localparam int         IDX_BITS   = $clog2(MEM_DEPTH);
    localparam logic [2:0] MAX_SIZE   = 3'(LANE_BITS);
    localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_STATES);

`ifdef AHB_SUB_ERR_EN
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA
    } state_t;
`endif

    state_t                state_q, state_d;
    logic [3:0]            wait_cnt_q, wait_cnt_d;
    logic [IDX_BITS-1:0]   idx_q, idx_d;
    logic [BYTE_LANES-1:0] size_mask_q, size_mask_d;
    logic                  write_q, write_d;

    logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

    logic                  accept;
    logic                  addr_err;
    logic [2:0]            eff_size;
    int                    n_bytes;
    int                    lane_base;
    logic [BYTE_LANES-1:0] addr_size_mask;
    logic                  mem_we;
    logic [DATA_WIDTH-1:0] wr_word;

    // Burst type, protection and lock carry no meaning for a plain SRAM.
    logic unused_ok;
    assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HADDR};

    // A transfer is taken only on an edge where HREADY is high and HTRANS is
    // NONSEQ or SEQ; IDLE and BUSY fall through with no access.
    assign accept = HREADY && HTRANS[1];

    // Decode the address-phase size and low address bits into a lane mask.
    // NOTE: every variable written in a combinational block gets a value on
    // every path (here by assigning first), otherwise a latch is inferred.
    always_comb begin
        eff_size       = (HSIZE > MAX_SIZE) ? MAX_SIZE : HSIZE;
        n_bytes        = 1 << eff_size;
        lane_base      = int'(HADDR[LANE_BITS-1:0]) & ~(n_bytes - 1);
        addr_size_mask = '0;
        for (int i = 0; i < BYTE_LANES; i++) begin
            addr_size_mask[i] = (i >= lane_base) && (i < lane_base + n_bytes);
        end
    end

`ifdef AHB_SUB_ERR_EN
    // Flag transfers that fall outside the array, exceed the bus width or are
    // not aligned to their own size.
    always_comb begin
        addr_err = 1'b0;
        if (HADDR[ADDR_WIDTH-1:LANE_BITS+IDX_BITS] != '0) begin
            addr_err = 1'b1;
        end
        if (HSIZE > MAX_SIZE) begin
            addr_err = 1'b1;
        end
        if ((int'(HADDR[LANE_BITS-1:0]) & (n_bytes - 1)) != 0) begin
            addr_err = 1'b1;
        end
    end
`else
    assign addr_err = 1'b0;
`endif

    // Next-state logic: wait-state countdown and address-phase capture.
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        idx_d       = idx_q;
        size_mask_d = size_mask_q;
        write_d     = write_q;
        case (state_q)
            ST_WAIT: begin
                if (wait_cnt_q <= 4'd1) begin
                    state_d    = ST_DATA;
                    wait_cnt_d = 4'd0;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
`ifdef AHB_SUB_ERR_EN
            ST_ERR1: begin
                state_d = ST_ERR2;
            end
`endif
            default: begin
                // IDLE, DATA and ERR2 all drive HREADY high, so a new address
                // phase may complete here.
                state_d = ST_IDLE;
                if (accept) begin
                    idx_d       = HADDR[LANE_BITS +: IDX_BITS];
                    size_mask_d = addr_size_mask;
                    write_d     = HWRITE;
                    if (addr_err) begin
`ifdef AHB_SUB_ERR_EN
                        state_d = ST_ERR1;
`endif
                    end else if (WAIT_STATES > 0) begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
        endcase
    end

    // State and address-phase registers, synchronously reset.
    // NOTE: sequential state uses non-blocking assignments so every register
    // updates from the values present before the edge.
    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            wait_cnt_q  <= 4'd0;
            idx_q       <= '0;
            size_mask_q <= '0;
            write_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            idx_q       <= idx_d;
            size_mask_q <= size_mask_d;
            write_q     <= write_d;
        end
    end

    // Bus outputs follow the data-phase state; read data only during a read.
    always_comb begin
        HREADY = 1'b1;
        HRESP  = 1'b0;
        HRDATA = '0;
        case (state_q)
            ST_WAIT: begin
                HREADY = 1'b0;
            end
`ifdef AHB_SUB_ERR_EN
            ST_ERR1: begin
                HREADY = 1'b0;
                HRESP  = 1'b1;
            end
            ST_ERR2: begin
                HRESP = 1'b1;
            end
`endif
            default: begin
            end
        endcase
        if (!write_q && (state_q == ST_WAIT || state_q == ST_DATA)) begin
            HRDATA = mem[idx_q];
        end
    end

    // Writes commit on the edge that ends an OKAY data phase, which is also
    // the edge taking the next address, so a following read sees new data.
    assign mem_we = (state_q == ST_DATA) && write_q;

    // Merge the enabled write lanes into the stored word.
    always_comb begin
        wr_word = mem[idx_q];
        for (int i = 0; i < BYTE_LANES; i++) begin
            if (size_mask_q[i] && HWSTRB[i]) begin
                wr_word[8*i +: 8] = HWDATA[8*i +: 8];
            end
        end
    end

    // SRAM write port; reset only blocks the write so an aborted transfer
    // leaves memory untouched.
    // NOTE: the array itself is never reset -- a RAM macro has no reset and
    // clearing it would need MEM_DEPTH cycles or a flop-based array.
    always_ff @(posedge HCLK) begin
        if (HRESETn && mem_we) begin
            mem[idx_q] <= wr_word;
        end
    end

endmodule

// File: tb/tb_ahb_sram_subordinate.sv
// tb_ahb_sram_subordinate
// Two instances share clock and reset: bus 0 has WAIT_STATES=0, bus 1 has
// WAIT_STATES=3. Each bus is driven from a table of pipelined transfers;
// expected responses are queued when a transfer's address phase is taken
// and compared when its data phase completes. Hand-written sequences cover
// HTRANS changes during wait states and reset during a write.
module tb_ahb_sram_subordinate;

    typedef struct {
        logic        write;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic [31:0] wdata;
        logic [3:0]  strb;
        logic [31:0] exp_rdata;
        logic        exp_resp;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] haddr  [2];
    logic        hwrite [2];
    logic [2:0]  hsize  [2];
    logic [1:0]  htrans [2];
    logic [31:0] hwdata [2];
    logic [3:0]  hwstrb [2];

    logic        hready0, hresp0;
    logic [31:0] hrdata0;
    logic        hready1, hresp1;
    logic [31:0] hrdata1;

    int          n_vec  = 0;
    int          n_miss = 0;

    vec_t        tbl  [$];
    vec_t        sb_q [$];

    always #5 clk = ~clk;

    ahb_sram_subordinate #(.WAIT_STATES(0)) u_dut_ws0 (
        .HCLK(clk), .HRESETn(rst_n),
        .HADDR(haddr[0]), .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HTRANS(htrans[0]),
        .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
        .HWDATA(hwdata[0]), .HWSTRB(hwstrb[0]),
        .HREADY(hready0), .HRESP(hresp0), .HRDATA(hrdata0)
    );

    ahb_sram_subordinate #(.WAIT_STATES(3)) u_dut_ws3 (
        .HCLK(clk), .HRESETn(rst_n),
        .HADDR(haddr[1]), .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HTRANS(htrans[1]),
        .HBURST(3'b000), .HPROT(4'b0011), .HMASTLOCK(1'b0),
        .HWDATA(hwdata[1]), .HWSTRB(hwstrb[1]),
        .HREADY(hready1), .HRESP(hresp1), .HRDATA(hrdata1)
    );

    function automatic logic get_ready(input int b);
        return (b == 0) ? hready0 : hready1;
    endfunction

    function automatic logic get_resp(input int b);
        return (b == 0) ? hresp0 : hresp1;
    endfunction

    function automatic logic [31:0] get_rdata(input int b);
        return (b == 0) ? hrdata0 : hrdata1;
    endfunction

    // OKAY data phases take the bus's wait states; ERROR always has one.
    function automatic int exp_waits(input int b, input logic resp);
        if (resp) return 1;
        return (b == 0) ? 0 : 3;
    endfunction

    function automatic vec_t wr(input logic [31:0] a, input logic [2:0] sz,
                                input logic [31:0] d, input logic [3:0] s,
                                input logic er);
        vec_t t;
        t.write = 1'b1; t.trans = 2'b10; t.addr = a; t.size = sz;
        t.wdata = d; t.strb = s; t.exp_rdata = 32'h0; t.exp_resp = er;
        return t;
    endfunction

    function automatic vec_t rd(input logic [31:0] a, input logic [2:0] sz,
                                input logic [31:0] exp, input logic er);
        vec_t t;
        t.write = 1'b0; t.trans = 2'b10; t.addr = a; t.size = sz;
        t.wdata = 32'h0; t.strb = 4'h0; t.exp_rdata = exp; t.exp_resp = er;
        return t;
    endfunction

    function automatic vec_t nop(input logic [1:0] tr, input logic [31:0] a);
        vec_t t;
        t.write = 1'b1; t.trans = tr; t.addr = a; t.size = 3'd2;
        t.wdata = 32'h0; t.strb = 4'h0; t.exp_rdata = 32'h0; t.exp_resp = 1'b0;
        return t;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive_idle(input int b);
        htrans[b] = 2'b00; haddr[b] = 32'h0; hwrite[b] = 1'b0; hsize[b] = 3'd2;
        hwdata[b] = 32'h0; hwstrb[b] = 4'h0;
    endtask

    // Apply the table back to back on bus b; each address phase overlaps the
    // previous transfer's data phase.
    task automatic run_table(input int b);
        vec_t cur;
        vec_t pend;
        vec_t e;
        logic have_pend;
        int   waits;
        have_pend = 1'b0;
        pend      = nop(2'b00, 32'h0);
        for (int i = 0; i <= tbl.size(); i++) begin
            cur = (i < tbl.size()) ? tbl[i] : nop(2'b00, 32'h0);
            htrans[b] = cur.trans;
            haddr[b]  = cur.addr;
            hwrite[b] = cur.write;
            hsize[b]  = cur.size;
            hwdata[b] = have_pend ? pend.wdata : 32'h0;
            hwstrb[b] = have_pend ? pend.strb : 4'h0;
            waits = 0;
            @(negedge clk);
            while (!get_ready(b) && waits < 40) begin
                if (have_pend) begin
                    check($sformatf("b%0d v%0d wait_hresp", b, i - 1),
                          32'(get_resp(b)), 32'(pend.exp_resp));
                end
                waits++;
                @(negedge clk);
            end
            if (have_pend) begin
                e = sb_q.pop_front();
                check($sformatf("b%0d v%0d waits", b, i - 1), 32'(waits),
                      32'(exp_waits(b, e.exp_resp)));
                check($sformatf("b%0d v%0d hresp", b, i - 1), 32'(get_resp(b)),
                      32'(e.exp_resp));
                check($sformatf("b%0d v%0d hrdata", b, i - 1), get_rdata(b), e.exp_rdata);
            end
            @(posedge clk);
            #1;
            if (cur.trans[1]) begin
                sb_q.push_back(cur);
            end
            have_pend = cur.trans[1];
            pend      = cur;
        end
        drive_idle(b);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int waits;
        rst_n = 1'b0;
        drive_idle(0);
        drive_idle(1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst b0 hready", 32'(hready0), 32'h1);
        check("rst b0 hresp",  32'(hresp0),  32'h0);
        check("rst b0 hrdata", hrdata0,      32'h0);
        check("rst b1 hready", 32'(hready1), 32'h1);
        check("rst b1 hresp",  32'(hresp1),  32'h0);
        check("rst b1 hrdata", hrdata1,      32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ---- bus 0, no wait states ----
        tbl.delete();
        tbl.push_back(wr(32'h10, 3'd2, 32'hDEADBEEF, 4'hF, 1'b0));
        tbl.push_back(rd(32'h10, 3'd2, 32'hDEADBEEF, 1'b0));
        tbl.push_back(wr(32'h04, 3'd2, 32'h11223344, 4'hF, 1'b0));
        tbl.push_back(wr(32'h06, 3'd1, 32'hBEEF0000, 4'h4, 1'b0));
        tbl.push_back(rd(32'h04, 3'd2, 32'h11EF3344, 1'b0));
        tbl.push_back(nop(2'b00, 32'h04));
        tbl.push_back(wr(32'h20, 3'd2, 32'hA5A5A5A5, 4'hF, 1'b0));
        tbl.push_back(wr(32'h23, 3'd0, 32'h77000000, 4'hF, 1'b0));
        tbl.push_back(nop(2'b01, 32'h20));
        tbl.push_back(rd(32'h20, 3'd2, 32'h77A5A5A5, 1'b0));
        tbl.push_back(wr(32'h30, 3'd2, 32'h12345678, 4'hF, 1'b0));
        tbl.push_back(wr(32'h30, 3'd2, 32'hFFFFFFFF, 4'h0, 1'b0));
        tbl.push_back(wr(32'h32, 3'd1, 32'hCAFE0000, 4'hF, 1'b0));
        tbl.push_back(rd(32'h30, 3'd2, 32'hCAFE5678, 1'b0));
`ifdef AHB_SUB_ERR_EN
        tbl.push_back(rd(32'h1000, 3'd2, 32'h0, 1'b1));
        tbl.push_back(nop(2'b00, 32'h0));
        tbl.push_back(wr(32'h1004, 3'd2, 32'h0BADF00D, 4'hF, 1'b1));
        tbl.push_back(rd(32'h04, 3'd2, 32'h11EF3344, 1'b0));
        tbl.push_back(wr(32'h12, 3'd2, 32'h01020304, 4'hF, 1'b1));
        tbl.push_back(wr(32'h10, 3'd3, 32'h01020304, 4'hF, 1'b1));
        tbl.push_back(rd(32'h10, 3'd2, 32'hDEADBEEF, 1'b0));
`else
        tbl.push_back(wr(32'h1004, 3'd2, 32'h0BADF00D, 4'hF, 1'b0));
        tbl.push_back(rd(32'h04, 3'd2, 32'h0BADF00D, 1'b0));
        tbl.push_back(rd(32'h1010, 3'd2, 32'hDEADBEEF, 1'b0));
        tbl.push_back(wr(32'h40, 3'd2, 32'h00000000, 4'hF, 1'b0));
        tbl.push_back(wr(32'h42, 3'd2, 32'h01020304, 4'hF, 1'b0));
        tbl.push_back(rd(32'h40, 3'd2, 32'h01020304, 1'b0));
        tbl.push_back(wr(32'h44, 3'd3, 32'hFEEDFACE, 4'hF, 1'b0));
        tbl.push_back(rd(32'h44, 3'd2, 32'hFEEDFACE, 1'b0));
`endif
        run_table(0);

        // ---- bus 1, three wait states ----
        tbl.delete();
        tbl.push_back(wr(32'h00, 3'd2, 32'h11223344, 4'hF, 1'b0));
        tbl.push_back(wr(32'h02, 3'd0, 32'h00AA0000, 4'hF, 1'b0));
        tbl.push_back(rd(32'h00, 3'd2, 32'h11AA3344, 1'b0));
        tbl.push_back(wr(32'h08, 3'd2, 32'h55555555, 4'hF, 1'b0));
        tbl.push_back(rd(32'h08, 3'd2, 32'h55555555, 1'b0));
`ifdef AHB_SUB_ERR_EN
        tbl.push_back(rd(32'h1000, 3'd2, 32'h0, 1'b1));
        tbl.push_back(rd(32'h00, 3'd2, 32'h11AA3344, 1'b0));
`endif
        run_table(1);

        // ---- HTRANS changes while HREADY is low are ignored ----
        htrans[1] = 2'b10; haddr[1] = 32'h0; hwrite[1] = 1'b0; hsize[1] = 3'd2;
        @(posedge clk);
        #1;
        htrans[1] = 2'b10; haddr[1] = 32'h8; hwrite[1] = 1'b1;
        hwdata[1] = 32'h0; hwstrb[1] = 4'hF;
        waits = 0;
        @(negedge clk);
        while (!hready1 && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        check("ign waits", 32'(waits), 32'd3);
        check("ign hrdata", hrdata1, 32'h11AA3344);
        htrans[1] = 2'b00;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("ign hready after", 32'(hready1), 32'h1);
        check("ign hrdata after", hrdata1, 32'h0);
        drive_idle(1);

        // ---- reset during the second wait cycle of a write ----
        @(posedge clk);
        #1;
        htrans[1] = 2'b10; haddr[1] = 32'h8; hwrite[1] = 1'b1; hsize[1] = 3'd2;
        @(posedge clk);
        #1;
        htrans[1] = 2'b00; hwdata[1] = 32'hFFFFFFFF; hwstrb[1] = 4'hF;
        @(posedge clk);
        #1;
        check("rstmid hready before", 32'(hready1), 32'h0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check("rstmid hready", 32'(hready1), 32'h1);
        check("rstmid hresp",  32'(hresp1),  32'h0);
        check("rstmid hrdata", hrdata1,      32'h0);
        rst_n = 1'b1;
        drive_idle(1);

        tbl.delete();
        tbl.push_back(rd(32'h08, 3'd2, 32'h55555555, 1'b0));
        run_table(1);
        tbl.delete();
        tbl.push_back(rd(32'h10, 3'd2, 32'hDEADBEEF, 1'b0));
        run_table(0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
